ps2input_rx: RTL and testbench
==============================

Name: ps2input_rx

Overview:
AXI-Stream receiver that takes 128-bit input frames (feature maps/weights) from the PS DMA and delivers them to the systolic conv engine input. It is the inbound counterpart of the accelerator-to-PS output stream path.
- Buffers beats in a small FIFO to decouple DMA bursts from engine stalls.
- Zeroes unkept bytes.
- Frames data by a configured beat count, regenerates tlast downstream, and flags tlast mismatches from the DMA.

Parameters:
DATA_W, 128, stream data width in bits
KEEP_W, 16, byte-enable width (DATA_W/8)
LEN_W, 16, width of frame-length configuration and beat counter
FIFO_DEPTH, 4, buffer entries (power of 2, >=2)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
cfg_frame_len  input  LEN_W  expected beats per frame; sampled on first beat of each frame
err_clr  input  1  clears sticky error flags
s_axis_ps2input_tdata  input  DATA_W  data from PS DMA
s_axis_ps2input_tkeep  input  KEEP_W  byte enables
s_axis_ps2input_tlast  input  1  DMA end-of-packet marker
s_axis_ps2input_tvalid  input  1  upstream valid
s_axis_ps2input_tready  output  1  ready to DMA
m_axis_ps2input_tdata  output  DATA_W  data to conv engine
m_axis_ps2input_tlast  output  1  regenerated end-of-frame
m_axis_ps2input_tvalid  output  1  downstream valid
m_axis_ps2input_tready  input  1  engine ready
frame_done  output  1  one-cycle pulse per completed frame
err_early_last  output  1  sticky: tlast seen before expected last beat
err_late_last  output  1  sticky: expected last beat arrived without tlast

Behaviour:
- Reset (rst_n low, async): all of the following are 0:
  - FIFO pointers and occupancy; beat_cnt; len_q
  - s/m tvalid, m tlast, m tdata
  - s tready, frame_done, both error flags
- tready is held 0 until the first clk edge after rst_n deasserts; a reset mid-frame discards buffered beats and restarts framing at beat 0.
- Accept = s_tvalid & s_tready. Pop = m_tvalid & m_tready.
- s_tready = ready_en & (occupancy != FIFO_DEPTH). Full FIFO deasserts tready even if a pop occurs the same cycle; there is no combinational pass-through.
- Simultaneous accept and pop when not full: occupancy unchanged, both proceed.
- Stored data: byte i = tdata[8i+7:8i] if tkeep[i], else 8'h00.
- m_tvalid = occupancy != 0. m_tdata/m_tlast are driven from the registered head entry.
- Latency: a beat accepted at edge N is visible on m_axis after edge N (1 cycle) when the FIFO was empty.
- m_tdata/m_tlast stay stable while m_tvalid & !m_tready.
- Framing:
  - eff_len = (beat_cnt==0 ? cfg_frame_len : len_q); a value of 0 is treated as 1.
  - len_q latches eff_len on the first accept of a frame.
  - last_beat = accept & (beat_cnt == eff_len-1 | s_tlast).
  - On last_beat: stored tlast=1, beat_cnt<=0, frame_done pulses at the next cycle for exactly 1 cycle.
  - Otherwise, on accept: beat_cnt+1.
- Errors:
  - err_early_last sets on accept with s_tlast=1 and beat_cnt < eff_len-1; the frame ends there.
  - err_late_last sets on accept with beat_cnt == eff_len-1 and s_tlast=0; the frame ends there, and subsequent beats start a new frame.
  - Flags are sticky until err_clr. A set and err_clr in the same cycle leaves the flag set.
- Back-to-back frames need no idle cycle: the beat after a last_beat is beat 0 of the next frame and samples cfg_frame_len.

Test Plan:
1. Reset then cfg_frame_len=4, 4 beats tvalid continuous with tkeep=16'hffff, tlast on beat 4, m_tready=1 -> 4 beats out, tlast on 4th, first m_tvalid 1 cycle after first accept, frame_done one pulse, no errors.
2. Backpressure: m_tready=0, stream 6 beats -> tready drops after 4 accepted, 0 lost. Release m_tready -> all 6 out in order, data stable while stalled.
3. tkeep=16'h00ff on final beat with tdata all 8'hAA -> output upper 8 bytes 8'h00, lower 8 bytes 8'hAA.
4. cfg_frame_len=4, tlast on beat 2 -> err_early_last=1, m tlast on beat 2, frame_done pulses. Next 4 beats form a clean frame. err_clr -> flag 0.
5. cfg_frame_len=3, no tlast from DMA -> m tlast on beat 3, err_late_last=1. cfg_frame_len=0 with one beat -> treated as 1-beat frame.
6. Assert rst_n low mid-frame with 2 beats buffered -> m_tvalid=0 and s_tready=0 immediately. After release, tready rises one edge later and the first beat starts beat_cnt=0.

Source files
------------

// File: rtl/ps2input_rx.sv
// ps2input_rx
// Inbound AXI-Stream path from the PS DMA to the systolic conv engine.
// Beats are byte-masked by tkeep, buffered in a small FIFO, and re-framed by a
// configured beat count. The downstream tlast is regenerated from that count.
// DMA tlast markers that disagree with the count are flagged in sticky bits.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cfg_frame_len              beats per frame, sampled on beat 0 of each frame
//   err_clr                    clears the sticky error flags
//   s_axis_ps2input_*          slave stream from the DMA (tdata/tkeep/tlast/tvalid/tready)
//   m_axis_ps2input_*          master stream to the engine (tdata/tlast/tvalid/tready)
//   frame_done                 one-cycle pulse after each frame's last beat is accepted
//   err_early_last             sticky: DMA tlast arrived before the expected last beat
//   err_late_last              sticky: expected last beat arrived without DMA tlast
module ps2input_rx #(
  parameter int DATA_W     = 128,
  parameter int KEEP_W     = 16,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LEN_W-1:0]  cfg_frame_len,
  input  logic              err_clr,
  input  logic [DATA_W-1:0] s_axis_ps2input_tdata,
  input  logic [KEEP_W-1:0] s_axis_ps2input_tkeep,
  input  logic              s_axis_ps2input_tlast,
  input  logic              s_axis_ps2input_tvalid,
  output logic              s_axis_ps2input_tready,
  output logic [DATA_W-1:0] m_axis_ps2input_tdata,
  output logic              m_axis_ps2input_tlast,
  output logic              m_axis_ps2input_tvalid,
  input  logic              m_axis_ps2input_tready,
  output logic              frame_done,
  output logic              err_early_last,
  output logic              err_late_last
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Storage and pointers
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0]     r_mem_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_mem_last;
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_ready_en;

  logic [LEN_W-1:0]      r_beat_cnt;
  logic [LEN_W-1:0]      r_len_q;
  logic                  r_frame_done;
  logic                  r_err_early;
  logic                  r_err_late;

  logic                  w_full;
  logic                  w_accept;
  logic                  w_pop;
  logic [DATA_W-1:0]     w_masked;
  logic [LEN_W-1:0]      w_eff_len_raw;
  logic [LEN_W-1:0]      w_eff_len;
  logic [LEN_W-1:0]      w_last_idx;
  logic                  w_at_last_idx;
  logic                  w_last_beat;
  logic                  w_set_early;
  logic                  w_set_late;

  // Ready depends only on registered state: a pop in the same cycle does not
  // free a slot for the incoming beat, so there is no tready->tready path.
  assign w_full                 = (r_count == DEPTH_C);
  assign s_axis_ps2input_tready = r_ready_en & ~w_full;
  assign w_accept               = s_axis_ps2input_tvalid & s_axis_ps2input_tready;
  assign m_axis_ps2input_tvalid = (r_count != '0);
  assign w_pop                  = m_axis_ps2input_tvalid & m_axis_ps2input_tready;

  // Head entry drives the outputs directly; it cannot change while stalled
  // because the read pointer only moves on pop and a full FIFO blocks writes.
  assign m_axis_ps2input_tdata  = r_mem_data[r_rd_ptr];
  assign m_axis_ps2input_tlast  = r_mem_last[r_rd_ptr];

  // Zero the bytes that the DMA did not mark as kept.
  generate
    for (genvar gi = 0; gi < KEEP_W; gi++) begin : g_keep
      assign w_masked[8*gi +: 8] = s_axis_ps2input_tkeep[gi] ? s_axis_ps2input_tdata[8*gi +: 8]
                                                             : 8'h00;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Framing
  // ---------------------------------------------------------------------------
  // Beat 0 takes the live configuration; later beats use the latched copy so a
  // config change mid-frame does not disturb the frame in flight.
  assign w_eff_len_raw = (r_beat_cnt == '0) ? cfg_frame_len : r_len_q;
  assign w_eff_len     = (w_eff_len_raw == '0) ? LEN_W'(1) : w_eff_len_raw;
  assign w_last_idx    = w_eff_len - LEN_W'(1);
  assign w_at_last_idx = (r_beat_cnt == w_last_idx);
  assign w_last_beat   = w_accept & (w_at_last_idx | s_axis_ps2input_tlast);
  assign w_set_early   = w_accept & s_axis_ps2input_tlast & (r_beat_cnt < w_last_idx);
  assign w_set_late    = w_accept & w_at_last_idx & ~s_axis_ps2input_tlast;

  // ---------------------------------------------------------------------------
  // FIFO entries: one register slice per slot, written when the write pointer
  // points at it.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_mem_data[gi] <= '0;
          r_mem_last[gi] <= 1'b0;
        end else if (w_accept && (r_wr_ptr == AW'(gi))) begin
          r_mem_data[gi] <= w_masked;
          r_mem_last[gi] <= w_last_beat;
        end
      end
    end
  endgenerate

  // Pointers, occupancy and the post-reset ready enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_accept) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Beat counter, latched length and frame-done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt   <= '0;
      r_len_q      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_last_beat;
      if (w_accept && (r_beat_cnt == '0)) r_len_q <= w_eff_len;
      if (w_last_beat)   r_beat_cnt <= '0;
      else if (w_accept) r_beat_cnt <= r_beat_cnt + LEN_W'(1);
    end
  end

  // Sticky error flags; a new error wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_early <= 1'b0;
      r_err_late  <= 1'b0;
    end else begin
      if (w_set_early)  r_err_early <= 1'b1;
      else if (err_clr) r_err_early <= 1'b0;
      if (w_set_late)   r_err_late  <= 1'b1;
      else if (err_clr) r_err_late  <= 1'b0;
    end
  end

  assign frame_done     = r_frame_done;
  assign err_early_last = r_err_early;
  assign err_late_last  = r_err_late;

endmodule

// File: tb/tb_ps2input_rx.sv
module tb_ps2input_rx;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  cfg_frame_len = '0;
  logic         err_clr = 1'b0;
  logic [127:0] s_tdata = '0;
  logic [15:0]  s_tkeep = '0;
  logic         s_tlast = 1'b0;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic [127:0] m_tdata;
  logic         m_tlast;
  logic         m_tvalid;
  logic         m_tready = 1'b0;
  logic         frame_done;
  logic         err_early_last;
  logic         err_late_last;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [127:0] d;
    logic         l;
  } beat_t;

  beat_t out_q[$];
  int    fd_cnt  = 0;
  int    acc_cnt = 0;

  always #5 clk = ~clk;

  ps2input_rx dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .cfg_frame_len          (cfg_frame_len),
    .err_clr                (err_clr),
    .s_axis_ps2input_tdata  (s_tdata),
    .s_axis_ps2input_tkeep  (s_tkeep),
    .s_axis_ps2input_tlast  (s_tlast),
    .s_axis_ps2input_tvalid (s_tvalid),
    .s_axis_ps2input_tready (s_tready),
    .m_axis_ps2input_tdata  (m_tdata),
    .m_axis_ps2input_tlast  (m_tlast),
    .m_axis_ps2input_tvalid (m_tvalid),
    .m_axis_ps2input_tready (m_tready),
    .frame_done             (frame_done),
    .err_early_last         (err_early_last),
    .err_late_last          (err_late_last)
  );

  // Inputs change at posedge+1, so the negedge view predicts the next edge.
  always @(negedge clk) begin
    if (m_tvalid && m_tready) out_q.push_back('{d: m_tdata, l: m_tlast});
    if (frame_done) fd_cnt++;
    if (s_tvalid && s_tready) acc_cnt++;
  end

  function automatic logic [127:0] dat(input int i);
    return {4{32'hC0DE_0000 + 32'(i)}};
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send_beat(input logic [127:0] d, input logic [15:0] k, input logic l);
    int n;
    n = 0;
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && n < 60) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (!s_tready) begin
      errors++;
      $display("FAIL send_timeout: beat %h not accepted, tready=%b required 1", d[31:0], s_tready);
      s_tvalid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic s_idle();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({s_tready, m_tvalid, m_tlast, frame_done, err_early_last, err_late_last} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {s_tready, m_tvalid, m_tlast, frame_done, err_early_last, err_late_last});
    end
    checks++;
    if (m_tdata !== 128'h0) begin
      errors++;
      $display("FAIL reset_tdata: got %h required 0", m_tdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (s_tready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_hold: got %b required 0", s_tready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (s_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_rise: got %b required 1", s_tready);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int fd0;
    cfg_frame_len = 16'd4;
    m_tready = 1'b1;
    out_q.delete();
    fd0 = fd_cnt;
    checks++;
    if (m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle_valid: got %b required 0", m_tvalid);
    end
    send_beat(dat(0), 16'hffff, 1'b0);
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== dat(0)) begin
      errors++;
      $display("FAIL basic_latency: valid=%b data=%h required 1 %h", m_tvalid, m_tdata, dat(0));
    end
    for (int i = 1; i < 4; i++) send_beat(dat(i), 16'hffff, i == 3);
    s_idle();
    wait_cycles(4);
    checks++;
    if (out_q.size() != 4) begin
      errors++;
      $display("FAIL basic_count: got %0d beats required 4", out_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (out_q[i].d !== dat(i) || out_q[i].l !== (i == 3)) begin
          errors++;
          $display("FAIL basic_beat%0d: got %h/%b required %h/%b", i, out_q[i].d, out_q[i].l, dat(i), i == 3);
        end
      end
    end
    checks++;
    if (fd_cnt - fd0 != 1) begin
      errors++;
      $display("FAIL basic_frame_done: got %0d pulse cycles required 1", fd_cnt - fd0);
    end
    checks++;
    if (err_early_last !== 1'b0 || err_late_last !== 1'b0) begin
      errors++;
      $display("FAIL basic_errors: got %b%b required 00", err_early_last, err_late_last);
    end
    $display("test_basic done");
  endtask

  task automatic test_backpressure();
    int acc0, fd0;
    logic stable_ok;
    cfg_frame_len = 16'd6;
    m_tready = 1'b0;
    out_q.delete();
    acc0 = acc_cnt;
    fd0 = fd_cnt;
    stable_ok = 1'b1;
    fork
      begin
        for (int i = 0; i < 6; i++) send_beat(dat(10 + i), 16'hffff, i == 5);
        s_idle();
      end
      begin
        wait_cycles(10);
        checks++;
        if (acc_cnt - acc0 != 4) begin
          errors++;
          $display("FAIL bp_accepted: got %0d required 4", acc_cnt - acc0);
        end
        checks++;
        if (s_tready !== 1'b0) begin
          errors++;
          $display("FAIL bp_ready_full: got %b required 0", s_tready);
        end
        repeat (3) begin
          if (m_tvalid !== 1'b1 || m_tdata !== dat(10) || m_tlast !== 1'b0) stable_ok = 1'b0;
          wait_cycles(1);
        end
        checks++;
        if (!stable_ok) begin
          errors++;
          $display("FAIL bp_stable: got %b/%h required 1/%h", m_tvalid, m_tdata, dat(10));
        end
        m_tready = 1'b1;
      end
    join
    wait_cycles(8);
    checks++;
    if (out_q.size() != 6) begin
      errors++;
      $display("FAIL bp_count: got %0d beats required 6", out_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (out_q[i].d !== dat(10 + i) || out_q[i].l !== (i == 5)) begin
          errors++;
          $display("FAIL bp_beat%0d: got %h/%b required %h/%b", i, out_q[i].d, out_q[i].l, dat(10 + i), i == 5);
        end
      end
    end
    checks++;
    if (fd_cnt - fd0 != 1) begin
      errors++;
      $display("FAIL bp_frame_done: got %0d required 1", fd_cnt - fd0);
    end
    $display("test_backpressure done");
  endtask

  task automatic test_keep();
    logic [127:0] exp_d;
    exp_d = 128'h0000_0000_0000_0000_AAAA_AAAA_AAAA_AAAA;
    cfg_frame_len = 16'd1;
    m_tready = 1'b1;
    out_q.delete();
    send_beat({16{8'hAA}}, 16'h00ff, 1'b1);
    s_idle();
    wait_cycles(3);
    checks++;
    if (out_q.size() != 1 || out_q[0].d !== exp_d || out_q[0].l !== 1'b1) begin
      errors++;
      $display("FAIL keep_mask: got n=%0d %h required n=1 %h tlast=1", out_q.size(),
               (out_q.size() > 0) ? out_q[0].d : 128'h0, exp_d);
    end
    $display("test_keep done");
  endtask

  task automatic test_early();
    int fd0;
    cfg_frame_len = 16'd4;
    m_tready = 1'b1;
    out_q.delete();
    fd0 = fd_cnt;
    send_beat(dat(20), 16'hffff, 1'b0);
    send_beat(dat(21), 16'hffff, 1'b1);
    s_idle();
    wait_cycles(3);
    checks++;
    if (err_early_last !== 1'b1 || err_late_last !== 1'b0) begin
      errors++;
      $display("FAIL early_flag: got %b%b required 10", err_early_last, err_late_last);
    end
    checks++;
    if (out_q.size() != 2 || out_q[0].l !== 1'b0 || out_q[1].l !== 1'b1 || fd_cnt - fd0 != 1) begin
      errors++;
      $display("FAIL early_frame: got n=%0d fd=%0d required n=2 tlast on 2nd fd=1", out_q.size(), fd_cnt - fd0);
    end
    out_q.delete();
    fd0 = fd_cnt;
    for (int i = 0; i < 4; i++) send_beat(dat(22 + i), 16'hffff, i == 3);
    s_idle();
    wait_cycles(3);
    checks++;
    if (out_q.size() != 4 || out_q[2].l !== 1'b0 || out_q[3].l !== 1'b1 || fd_cnt - fd0 != 1 ||
        err_late_last !== 1'b0) begin
      errors++;
      $display("FAIL early_next_frame: got n=%0d fd=%0d late=%b required n=4 fd=1 late=0",
               out_q.size(), fd_cnt - fd0, err_late_last);
    end
    err_clr = 1'b1;
    wait_cycles(1);
    err_clr = 1'b0;
    checks++;
    if (err_early_last !== 1'b0) begin
      errors++;
      $display("FAIL early_clear: got %b required 0", err_early_last);
    end
    // A new error in the same cycle as a clear must leave the flag set.
    err_clr = 1'b1;
    send_beat(dat(26), 16'hffff, 1'b1);
    err_clr = 1'b0;
    s_idle();
    checks++;
    if (err_early_last !== 1'b1) begin
      errors++;
      $display("FAIL early_set_vs_clr: got %b required 1", err_early_last);
    end
    err_clr = 1'b1;
    wait_cycles(1);
    err_clr = 1'b0;
    wait_cycles(2);
    $display("test_early done");
  endtask

  task automatic test_late();
    int fd0;
    cfg_frame_len = 16'd3;
    m_tready = 1'b1;
    out_q.delete();
    fd0 = fd_cnt;
    for (int i = 0; i < 3; i++) send_beat(dat(40 + i), 16'hffff, 1'b0);
    s_idle();
    wait_cycles(3);
    checks++;
    if (err_late_last !== 1'b1 || err_early_last !== 1'b0) begin
      errors++;
      $display("FAIL late_flag: got early=%b late=%b required 0 1", err_early_last, err_late_last);
    end
    checks++;
    if (out_q.size() != 3 || out_q[1].l !== 1'b0 || out_q[2].l !== 1'b1 || fd_cnt - fd0 != 1) begin
      errors++;
      $display("FAIL late_frame: got n=%0d fd=%0d required n=3 tlast on 3rd fd=1", out_q.size(), fd_cnt - fd0);
    end
    err_clr = 1'b1;
    wait_cycles(1);
    err_clr = 1'b0;
    cfg_frame_len = 16'd0;
    out_q.delete();
    fd0 = fd_cnt;
    send_beat(dat(43), 16'hffff, 1'b1);
    s_idle();
    wait_cycles(3);
    checks++;
    if (out_q.size() != 1 || out_q[0].l !== 1'b1 || fd_cnt - fd0 != 1 ||
        err_early_last !== 1'b0 || err_late_last !== 1'b0) begin
      errors++;
      $display("FAIL len_zero: got n=%0d fd=%0d err=%b%b required n=1 tlast fd=1 err=00",
               out_q.size(), fd_cnt - fd0, err_early_last, err_late_last);
    end
    $display("test_late done");
  endtask

  task automatic test_reset_mid();
    int fd0;
    cfg_frame_len = 16'd4;
    m_tready = 1'b0;
    send_beat(dat(50), 16'hffff, 1'b0);
    send_beat(dat(51), 16'hffff, 1'b0);
    s_idle();
    wait_cycles(1);
    checks++;
    if (m_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_buffered: got valid=%b required 1", m_tvalid);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: got valid=%b ready=%b required 0 0", m_tvalid, s_tready);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    checks++;
    if (s_tready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_ready_hold: got %b required 0", s_tready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_ready_rise: got ready=%b valid=%b required 1 0", s_tready, m_tvalid);
    end
    // Framing must restart at beat 0: with length 3, tlast on beat 2 is early.
    cfg_frame_len = 16'd3;
    m_tready = 1'b1;
    out_q.delete();
    fd0 = fd_cnt;
    send_beat(dat(60), 16'hffff, 1'b0);
    send_beat(dat(61), 16'hffff, 1'b1);
    s_idle();
    wait_cycles(3);
    checks++;
    if (out_q.size() != 2 || out_q[0].d !== dat(60) || out_q[1].d !== dat(61) || out_q[1].l !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_flush: got n=%0d first=%h required n=2 first=%h", out_q.size(),
               (out_q.size() > 0) ? out_q[0].d : 128'h0, dat(60));
    end
    checks++;
    if (err_early_last !== 1'b1 || err_late_last !== 1'b0 || fd_cnt - fd0 != 1) begin
      errors++;
      $display("FAIL rstmid_beatcnt: got err=%b%b fd=%0d required err=10 fd=1",
               err_early_last, err_late_last, fd_cnt - fd0);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_keep();
    test_early();
    test_late();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
